// File: rtl/muldiv_if.sv
// Bundle between the EX stage and the iterative multiply/divide engine.
// Launch side: Start, Op, operands, HiLoIn and Flush. Return side: Busy and the one-cycle HiLo write.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  // Start is only a request: it is acted on in a cycle where Busy=0 and Flush=0,
  // and ignored otherwise. WriteData is valid only while WriteEnable=1.
  logic [2:0]         Op;
  logic               Start;
  logic [WIDTH-1:0]   OperandA;
  logic [WIDTH-1:0]   OperandB;
  logic [2*WIDTH-1:0] HiLoIn;
  logic               Flush;
  logic               Busy;
  logic               WriteEnable;
  logic [2*WIDTH-1:0] WriteData;

  modport master (
    output Start, Op, OperandA, OperandB, HiLoIn, Flush,
    input  Busy, WriteEnable, WriteData
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, HiLoIn, Flush,
    output Busy, WriteEnable, WriteData
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/DIV/MADD/MSUB engine. It takes one operand step per cycle,
// then does a sign/accumulate fix-up and issues a single registered write to HiLo.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  muldiv_if.slave     bus,
  output logic [1:0]  dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] hilo_q, hilo_d;
  logic [2*WIDTH-1:0] wdata_q, wdata_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               we_q, we_d;

  logic               is_div, is_signed, is_acc, is_sub;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, result;
  logic [WIDTH-1:0]   quo, rem;

  // Op[2] selects the accumulate family, where Op[1] means subtract; otherwise Op[1] means divide.
  assign is_div    = ~op_q[2] & op_q[1];
  assign is_signed = ~op_q[0];
  assign is_acc    = op_q[2];
  assign is_sub    = op_q[2] & op_q[1];

  // a_q holds the multiplicand, or the dividend that turns into the quotient.
  // b_q holds the multiplier, shifted right each step, or the divisor, which stays put.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
  assign div_shift = {rem_q, a_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};

  always_comb begin
    prod   = (is_signed && (a_neg_q ^ b_neg_q)) ? -acc_q : acc_q;
    quo    = (is_signed && (a_neg_q ^ b_neg_q)) ? -a_q : a_q;
    rem    = (is_signed && a_neg_q) ? -rem_q : rem_q;
    result = prod;
    if (is_div) begin
      // A zero divisor reports Hi = dividend and Lo = all ones, whatever the signs.
      if (b_q == '0) result = {a_raw_q, {WIDTH{1'b1}}};
      else           result = {rem, quo};
    end else if (is_acc) begin
      result = is_sub ? (hilo_q - prod) : (hilo_q + prod);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    a_raw_d = a_raw_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    hilo_d  = hilo_q;
    wdata_d = wdata_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Flush) begin
          op_d    = bus.Op;
          a_raw_d = bus.OperandA;
          a_neg_d = ~bus.Op[0] & bus.OperandA[WIDTH-1];
          b_neg_d = ~bus.Op[0] & bus.OperandB[WIDTH-1];
          a_d     = a_neg_d ? -bus.OperandA : bus.OperandA;
          b_d     = b_neg_d ? -bus.OperandB : bus.OperandB;
          hilo_d  = bus.HiLoIn;
          acc_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.Flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div) begin
            rem_d = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            b_d   = b_q >> 1;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (bus.Flush) begin
          state_d = S_IDLE;
        end else begin
          wdata_d = result;
          we_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_raw_q <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      hilo_q  <= '0;
      wdata_q <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_raw_q <= a_raw_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      hilo_q  <= hilo_d;
      wdata_q <= wdata_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  assign bus.Busy        = (state_q != S_IDLE);
  assign bus.WriteEnable = we_q;
  assign bus.WriteData   = wdata_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed vectors, cycle-exact Busy/WriteEnable timing,
// flush, ignored restart and mid-operation reset.
module tb_muldiv_unit;
  localparam int W = 32;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] dbg_state;

  muldiv_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 Clock = ~Clock;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Start is high for the cycle that ends at posedge N. The loop then samples each later
  // cycle N+k at its falling edge, before driving anything new for that cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hilo, input logic [63:0] exp,
                        input int flush_at, input int restart_at, input int rst_at);
    int n_we = 0;
    int we_k = 0;
    int busy_err = 0;
    int end_k;
    bit abort;
    abort = (flush_at >= 1 && flush_at <= 33) || (rst_at > 0);
    end_k = (flush_at >= 1 && flush_at <= 33) ? flush_at : (rst_at > 0 ? rst_at : 34);
    if (!abort) exp_q.push_back(exp);
    @(negedge Clock);
    bus.Op = op; bus.OperandA = a; bus.OperandB = b; bus.HiLoIn = hilo; bus.Start = 1'b1;
    @(posedge Clock);
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (bus.Busy !== (k <= end_k)) busy_err++;
      if (bus.WriteEnable === 1'b1) begin
        n_we++;
        we_k = k;
        if (exp_q.size() > 0) check({tag, "_data"}, bus.WriteData, exp_q.pop_front());
        else check({tag, "_spurious_we"}, 64'(bus.WriteEnable), 64'd0);
      end
      if (k == 1) bus.Start = 1'b0;
      if (k == restart_at) begin
        bus.Op = 3'b001; bus.OperandA = 32'd5; bus.OperandB = 32'd7; bus.Start = 1'b1;
      end
      if (k == restart_at + 1) bus.Start = 1'b0;
      if (k == flush_at) bus.Flush = 1'b1;
      if (k == flush_at + 1) bus.Flush = 1'b0;
      if (k == rst_at) begin
        Reset = 1'b0;
        #1;
        check({tag, "_rst_busy"}, 64'(bus.Busy), 64'd0);
        check({tag, "_rst_we"}, 64'(bus.WriteEnable), 64'd0);
        check({tag, "_rst_wdata"}, bus.WriteData, 64'd0);
      end
      if (k == rst_at + 1) Reset = 1'b1;
    end
    check({tag, "_we_count"}, 64'(n_we), abort ? 64'd0 : 64'd1);
    if (!abort) check({tag, "_we_cycle"}, 64'(we_k), 64'd34);
    check({tag, "_busy_timing"}, 64'(busy_err), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    Reset = 1'b0;
    bus.Start = 1'b0; bus.Flush = 1'b0; bus.Op = 3'b000;
    bus.OperandA = '0; bus.OperandB = '0; bus.HiLoIn = '0;
    #1;
    check("reset_busy", 64'(bus.Busy), 64'd0);
    check("reset_we", 64'(bus.WriteEnable), 64'd0);
    check("reset_wdata", bus.WriteData, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    //      tag           op      A             B             HiLoIn                  expected
    run_op("multu_max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                  64'hFFFFFFFE_00000001, 0, 0, 0);
    run_op("mult_neg",   3'b000, 32'hFFFFFFFE, 32'd3,        64'h0,                  64'hFFFFFFFF_FFFFFFFA, 0, 0, 0);
    run_op("madd",       3'b100, 32'd2,        32'd3,        64'h00000000_00000001,  64'h00000000_00000007, 0, 0, 0);
    run_op("msubu",      3'b111, 32'd1,        32'd1,        64'h0,                  64'hFFFFFFFF_FFFFFFFF, 0, 0, 0);
    run_op("msub_neg",   3'b110, 32'hFFFFFFFD, 32'd4,        64'd10,                 64'h00000000_00000016, 0, 0, 0);
    run_op("div_neg",    3'b010, 32'hFFFFFFF9, 32'd2,        64'h0,                  64'hFFFFFFFF_FFFFFFFD, 0, 0, 0);
    run_op("div_ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h0,                  64'h00000000_80000000, 0, 0, 0);
    run_op("divu_zero",  3'b011, 32'h12345678, 32'd0,        64'h0,                  64'h12345678_FFFFFFFF, 0, 0, 0);
    run_op("div_zero",   3'b010, 32'h80000001, 32'd0,        64'h0,                  64'h80000001_FFFFFFFF, 0, 0, 0);
    run_op("divu_100_7", 3'b011, 32'd100,      32'd7,        64'h0,                  64'h00000002_0000000E, 0, 0, 0);
    run_op("flush_calc", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                  64'h0,                 10, 0, 0);
    run_op("flush_fix",  3'b001, 32'd9,        32'd9,        64'h0,                  64'h0,                 33, 0, 0);
    run_op("flush_done", 3'b001, 32'd6,        32'd7,        64'h0,                  64'h00000000_0000002A, 34, 0, 0);
    run_op("restart",    3'b001, 32'd11,       32'd13,       64'h0,                  64'h00000000_0000008F, 0, 5, 0);
    run_op("rst_mid",    3'b001, 32'hFFFFFFFF, 32'd2,        64'h0,                  64'h0,                 0, 0, 20);
    run_op("after_rst",  3'b001, 32'd3,        32'd4,        64'h0,                  64'h00000000_0000000C, 0, 0, 0);

    // Flush together with Start in IDLE must keep the engine idle.
    @(negedge Clock);
    bus.Op = 3'b001; bus.OperandA = 32'd2; bus.OperandB = 32'd2; bus.Start = 1'b1; bus.Flush = 1'b1;
    @(negedge Clock);
    check("idle_flush_busy", 64'(bus.Busy), 64'd0);
    check("idle_flush_state", 64'(dbg_state), 64'd0);
    bus.Start = 1'b0; bus.Flush = 1'b0;
    @(negedge Clock);
    check("idle_flush_wdata_held", bus.WriteData, 64'h00000000_0000000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
